// File: rtl/serial_in_deframer.sv
// serial_in_deframer
//   Receives the 19-slot serial frame produced by the upstream serial out
//   buffer and presents the decoded address/data word to a consumer.
//   Frame: start (Z=0,D=0), 7 address bits MSB first, gap (Z=1),
//   8 data bits MSB first, gap (Z=1), stop (Z=0,D=0).
//
// Ports
//   clk_in    in   system clock, all state updates on its rising edge
//   reset_n   in   synchronous active-low reset
//   InC       in   serial bit clock (asynchronous to clk_in)
//   InD       in   serial data
//   InZ       in   data line released (high-impedance) indication
//   Ack       in   consumer acknowledge of the held word
//   A_out     out  [6:0] received address
//   D_out     out  [7:0] received data
//   Valid     out  A_out/D_out hold an unacknowledged word
//   Busy      out  a frame is in progress
//   FrameErr  out  one-cycle pulse on protocol violation or timeout
//   Overrun   out  sticky: a good frame was dropped while Valid was high
//
// Output handshake: a word is offered while Valid=1; the consumer takes it by
// raising Ack for one cycle while Valid=1, and Valid drops on the next edge.
// A frame completing in the same cycle as Ack replaces the word instead and
// Valid stays high. Ack while Valid=0 is ignored.
module serial_in_deframer #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       InC,
  input  logic       InD,
  input  logic       InZ,
  input  logic       Ack,
  output logic [6:0] A_out,
  output logic [7:0] D_out,
  output logic       Valid,
  output logic       Busy,
  output logic       FrameErr,
  output logic       Overrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP1 = 3'd2,
    DATA = 3'd3,
    GAP2 = 3'd4,
    STOP = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, stateNext;
  logic [2:0] cSync;
  logic [1:0] dSync, zSync;
  logic       slot, slotD, slotZ;
  logic [2:0] slotCnt, slotCntNext;
  logic [6:0] addrSr, addrSrNext;
  logic [7:0] dataSr, dataSrNext;
  logic [7:0] toCnt;
  logic       timedOut;
  logic       errNext;
  logic       frameDone;

  // Bit slot = rising edge of the synchronised bit clock. Data and Z use the
  // same synchroniser depth so stage 2 of each lines up with the clock edge.
  assign slot  = cSync[1] & ~cSync[2];
  assign slotD = dSync[1];
  assign slotZ = zSync[1];

  // toCnt holds the number of cycles since the last slot, so the error pulse
  // lands exactly TIMEOUT cycles after the last slot's detection cycle.
  assign timedOut = (state != IDLE) && !slot && (toCnt == TIMEOUT_LAST);

  assign Busy = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    slotCntNext = slotCnt;
    addrSrNext  = addrSr;
    dataSrNext  = dataSr;
    errNext     = 1'b0;
    frameDone   = 1'b0;
    if (timedOut) begin
      stateNext = IDLE;
      errNext   = 1'b1;
    end else if (slot) begin
      case (state)
        IDLE: begin
          // Released-line slots and (Z=0,D=1) slots are line noise, not errors.
          if (!slotZ && !slotD) begin
            stateNext   = ADDR;
            slotCntNext = 3'd0;
            addrSrNext  = 7'd0;
            dataSrNext  = 8'd0;
          end
        end
        ADDR: begin
          if (slotZ) begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end else begin
            addrSrNext = {addrSr[5:0], slotD};
            if (slotCnt == 3'd6) begin
              stateNext   = GAP1;
              slotCntNext = 3'd0;
            end else begin
              slotCntNext = slotCnt + 3'd1;
            end
          end
        end
        GAP1: begin
          if (slotZ) begin
            stateNext   = DATA;
            slotCntNext = 3'd0;
          end else begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end
        end
        DATA: begin
          if (slotZ) begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end else begin
            dataSrNext  = {dataSr[6:0], slotD};
            slotCntNext = slotCnt + 3'd1;
            if (slotCnt == 3'd7) begin
              stateNext = GAP2;
            end
          end
        end
        GAP2: begin
          if (slotZ) begin
            stateNext = STOP;
          end else begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end
        end
        STOP: begin
          stateNext = IDLE;
          if (!slotZ && !slotD) begin
            frameDone = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cSync    <= 3'd0;
      dSync    <= 2'd0;
      zSync    <= 2'd0;
      slotCnt  <= 3'd0;
      addrSr   <= 7'd0;
      dataSr   <= 8'd0;
      toCnt    <= 8'd0;
      A_out    <= 7'd0;
      D_out    <= 8'd0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      cSync    <= {cSync[1:0], InC};
      dSync    <= {dSync[0], InD};
      zSync    <= {zSync[0], InZ};
      slotCnt  <= slotCntNext;
      addrSr   <= addrSrNext;
      dataSr   <= dataSrNext;
      FrameErr <= errNext;
      if (stateNext == IDLE) begin
        toCnt <= 8'd0;
      end else if (slot) begin
        toCnt <= 8'd1;
      end else begin
        toCnt <= toCnt + 8'd1;
      end
      if (frameDone && (!Valid || Ack)) begin
        A_out <= addrSr;
        D_out <= dataSr;
        Valid <= 1'b1;
      end else if (frameDone) begin
        Overrun <= 1'b1;
      end else if (Ack) begin
        Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_in_deframer.sv
// Bench for serial_in_deframer: a table of whole frames with their expected
// end-of-frame outputs, plus hand-written sequences for reset, idle noise,
// timeout and reset during a frame. Words the consumer should see are queued
// when a frame is driven and popped when the DUT presents a new word.
module tb_serial_in_deframer;

  localparam int TIMEOUT = 64;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       InC = 1'b0;
  logic       InD = 1'b0;
  logic       InZ = 1'b1;
  logic       Ack = 1'b0;
  logic [6:0] A_out;
  logic [7:0] D_out;
  logic       Valid, Busy, FrameErr, Overrun;

  serial_in_deframer #(.TIMEOUT(TIMEOUT)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .InC     (InC),
    .InD     (InD),
    .InZ     (InZ),
    .Ack     (Ack),
    .A_out   (A_out),
    .D_out   (D_out),
    .Valid   (Valid),
    .Busy    (Busy),
    .FrameErr(FrameErr),
    .Overrun (Overrun)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  int compared = 0;
  int mismatched = 0;
  int errPulses = 0;
  logic [14:0] exp_q[$];
  logic prevValid = 1'b0;
  logic prevAck = 1'b0;
  logic prevErr = 1'b0;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    int         badSlot;
    logic       ackStop;
    logic       loads;
    logic       ackAfter;
    int         expErrs;
    logic       expValid;
    logic [6:0] expA;
    logic [7:0] expD;
    logic       expOvr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: a new word appears when Valid rises, or when Valid stays high
  // across a cycle in which Ack was given (word replaced by a completing frame)
  always @(negedge clk_in) begin
    logic [14:0] expWord;
    if (reset_n) begin
      if (Valid && (!prevValid || prevAck)) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got A=0x%0h D=0x%0h, expected no word", A_out, D_out);
        end else begin
          expWord = exp_q.pop_front();
          check("word", {17'd0, A_out, D_out}, {17'd0, expWord});
        end
      end
      if (FrameErr) begin
        errPulses++;
        check("err_single_cycle", {31'd0, prevErr}, 32'd0);
      end
    end
    prevValid = Valid;
    prevAck   = Ack;
    prevErr   = FrameErr;
  end

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_slot(input logic sd, input logic sz);
    InC = 1'b0;
    InD = sd;
    InZ = sz;
    repeat (5) step();
    InC = 1'b1;
    repeat (5) step();
  endtask

  // Drives slots 0..lastSlot of a frame; badSlot (if >=0) is corrupted and
  // ends the frame. The stop slot is timed by hand to check load latency.
  task automatic send_frame(input logic [6:0] a, input logic [7:0] d, input int badSlot,
                            input int lastSlot, input logic ackStop, input logic loads);
    for (int i = 0; i <= lastSlot; i++) begin
      logic sd;
      logic sz;
      sd = 1'b0;
      sz = 1'b0;
      if (i >= 1 && i <= 7) sd = a[7-i];
      else if (i == 8 || i == 17) sz = 1'b1;
      else if (i >= 9 && i <= 16) sd = d[16-i];
      if (i == badSlot) begin
        if (i == 18) sd = 1'b1;
        else sz = ~sz;
      end
      if (i < 18) begin
        send_slot(sd, sz);
      end else begin
        InC = 1'b0;
        InD = sd;
        InZ = sz;
        repeat (5) step();
        InC = 1'b1;
        step();
        step();
        // stop slot is being detected in this cycle
        if (loads && !ackStop) check("valid_before_load", {31'd0, Valid}, 32'd0);
        if (ackStop) Ack = 1'b1;
        step();
        Ack = 1'b0;
        if (loads) check("valid_one_cycle_after_stop", {31'd0, Valid}, 32'd1);
        repeat (2) step();
      end
      if (i == badSlot) break;
    end
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic apply_row(input int idx, input vec_t v);
    int errsBefore;
    errsBefore = errPulses;
    if (v.loads) exp_q.push_back({v.a, v.d});
    send_frame(v.a, v.d, v.badSlot, 18, v.ackStop, v.loads);
    repeat (3) step();
    check($sformatf("row%0d_err_pulses", idx), errPulses - errsBefore, v.expErrs);
    check($sformatf("row%0d_valid", idx), {31'd0, Valid}, {31'd0, v.expValid});
    check($sformatf("row%0d_a_out", idx), {25'd0, A_out}, {25'd0, v.expA});
    check($sformatf("row%0d_d_out", idx), {24'd0, D_out}, {24'd0, v.expD});
    check($sformatf("row%0d_overrun", idx), {31'd0, Overrun}, {31'd0, v.expOvr});
    check($sformatf("row%0d_busy", idx), {31'd0, Busy}, 32'd0);
    if (v.ackAfter) begin
      pulse_ack();
      check($sformatf("row%0d_valid_after_ack", idx), {31'd0, Valid}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errsBefore;
    logic [6:0] ra;
    logic [7:0] rd;

    //               a      d      bad ackS ld ackA errs val expA   expD   ovr
    vecs[0]  = '{7'h7F, 8'hFF, -1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 7'h7F, 8'hFF, 1'b0};
    vecs[1]  = '{7'h41, 8'h9F, -1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 7'h41, 8'h9F, 1'b0};
    vecs[2]  = '{7'h12, 8'h34,  8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 7'h41, 8'h9F, 1'b0};
    vecs[3]  = '{7'h55, 8'hAA, -1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 7'h55, 8'hAA, 1'b0};
    vecs[4]  = '{7'h2A, 8'hC3, -1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 7'h2A, 8'hC3, 1'b0};
    vecs[5]  = '{7'h11, 8'h22, -1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 7'h2A, 8'hC3, 1'b1};
    vecs[6]  = '{7'h33, 8'h44, -1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 7'h33, 8'h44, 1'b1};
    vecs[7]  = '{7'h01, 8'h80,  3, 1'b0, 1'b0, 1'b0, 1, 1'b1, 7'h33, 8'h44, 1'b1};
    vecs[8]  = '{7'h7E, 8'h01, 12, 1'b0, 1'b0, 1'b0, 1, 1'b1, 7'h33, 8'h44, 1'b1};
    vecs[9]  = '{7'h00, 8'h00, 17, 1'b0, 1'b0, 1'b0, 1, 1'b1, 7'h33, 8'h44, 1'b1};
    vecs[10] = '{7'h5A, 8'hA5, 18, 1'b0, 1'b0, 1'b1, 1, 1'b1, 7'h33, 8'h44, 1'b1};

    // reset state
    repeat (3) step();
    check("reset_a_out", {25'd0, A_out}, 32'd0);
    check("reset_d_out", {24'd0, D_out}, 32'd0);
    check("reset_valid", {31'd0, Valid}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_frame_err", {31'd0, FrameErr}, 32'd0);
    check("reset_overrun", {31'd0, Overrun}, 32'd0);
    reset_n = 1'b1;
    repeat (3) step();

    // idle noise: released-line slots and (Z=0,D=1) slots are ignored
    send_slot(1'b1, 1'b0);
    send_slot(1'b0, 1'b1);
    send_slot(1'b1, 1'b1);
    check("idle_noise_busy", {31'd0, Busy}, 32'd0);
    check("idle_noise_errs", errPulses, 32'd0);

    // Ack with nothing held
    pulse_ack();
    check("ack_without_valid", {31'd0, Valid}, 32'd0);

    for (int i = 0; i < 11; i++) apply_row(i, vecs[i]);

    // random good frames
    for (int i = 0; i < 2; i++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      exp_q.push_back({ra, rd});
      send_frame(ra, rd, -1, 18, 1'b0, 1'b1);
      check("rand_a_out", {25'd0, A_out}, {25'd0, ra});
      check("rand_d_out", {24'd0, D_out}, {24'd0, rd});
      pulse_ack();
    end

    // timeout: bit clock stops after four address slots
    errsBefore = errPulses;
    send_frame(7'h6C, 8'h00, -1, 4, 1'b0, 1'b0);
    repeat (60) step();
    check("timeout_err_early", {31'd0, FrameErr}, 32'd0);
    check("timeout_busy_early", {31'd0, Busy}, 32'd1);
    step();
    check("timeout_err_pulse", {31'd0, FrameErr}, 32'd1);
    check("timeout_busy_idle", {31'd0, Busy}, 32'd0);
    step();
    check("timeout_err_end", {31'd0, FrameErr}, 32'd0);
    check("timeout_err_count", errPulses - errsBefore, 32'd1);
    InC = 1'b0;
    repeat (4) step();

    // reset during DATA: hold a word first so the reset is visible
    exp_q.push_back({7'h3C, 8'h5D});
    send_frame(7'h3C, 8'h5D, -1, 18, 1'b0, 1'b1);
    errsBefore = errPulses;
    send_frame(7'h0F, 8'hF0, -1, 11, 1'b0, 1'b0);
    InC = 1'b0;
    repeat (3) step();
    check("busy_in_data", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midreset_a_out", {25'd0, A_out}, 32'd0);
    check("midreset_d_out", {24'd0, D_out}, 32'd0);
    check("midreset_valid", {31'd0, Valid}, 32'd0);
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    check("midreset_overrun", {31'd0, Overrun}, 32'd0);
    repeat (4) step();
    check("midreset_no_err", errPulses - errsBefore, 32'd0);
    exp_q.push_back({7'h6B, 8'hE7});
    send_frame(7'h6B, 8'hE7, -1, 18, 1'b0, 1'b1);
    repeat (3) step();
    check("after_reset_a_out", {25'd0, A_out}, 32'h6B);
    check("after_reset_d_out", {24'd0, D_out}, 32'hE7);
    check("after_reset_overrun", {31'd0, Overrun}, 32'd0);

    // final report
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
